// File: rtl/wf_mx_xmit.sv
// wf_mx_xmit: WimpFi transmitter - buffers one frame and sends it Manchester-encoded on txd
module wf_mx_xmit #(
  parameter int         CLK_FREQ   = 100_000_000,
  parameter int         BIT_RATE   = 50_000,
  parameter logic [7:0] MAC_ADDR   = 8'h42,
  parameter int         EOF_BITS   = 2,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] xdata,
  input  logic       xwr,
  input  logic       xsnd,
  input  logic       cardet,
  output logic       txd,
  output logic       txen,
  output logic       xrdy,
  output logic [7:0] xerrcnt
);
  localparam int HALF = CLK_FREQ / (2 * BIT_RATE);
  localparam int HW   = HALF > 1 ? $clog2(HALF) : 1;
  localparam int EL   = EOF_BITS * 2 * HALF;
  localparam int EW   = $clog2(EL + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  typedef enum logic [3:0] {IDLE, WAIT_CLR, PRE, SFD, DEST, SRC, TYPE, DATA, CRC, EOF} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [CW-1:0] cnt, didx;
  logic [HW-1:0] hcnt;
  logic [EW-1:0] ecnt;
  logic [2:0]    bcnt;
  logic          ph, pcnt;
  logic [7:0]    sh, crc, crc_nx;
  logic          wr_ok, half_end, bit_end, in_crc, has_crc;
  assign wr_ok    = state == IDLE && xwr && cnt != CW'(FIFO_DEPTH);
  assign half_end = hcnt == HW'(HALF - 1);
  assign bit_end  = ph && half_end;
  assign in_crc   = state inside {DEST, SRC, TYPE, DATA};
  assign has_crc  = mem[1] == 8'h31;
  assign crc_nx   = (crc >> 1) ^ ((crc[0] ^ sh[0]) ? 8'hE0 : 8'h00);
  assign txen     = !(state inside {IDLE, WAIT_CLR});
  assign txd      = (state inside {IDLE, WAIT_CLR, EOF}) ? 1'b1 : sh[0] ^ ph;
  assign xrdy     = state == IDLE && cnt != CW'(FIFO_DEPTH);
  always_ff @(posedge clk)
    if (wr_ok) mem[cnt[AW-1:0]] <= xdata;
  // bit timing runs freely; the byte-boundary case below overrides sh/state on the last clk of a byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      didx    <= '0;
      hcnt    <= '0;
      ecnt    <= '0;
      bcnt    <= '0;
      ph      <= 1'b0;
      pcnt    <= 1'b0;
      sh      <= 8'hFF;
      crc     <= '0;
      xerrcnt <= '0;
    end else begin
      if (xwr && !wr_ok && xerrcnt != 8'hFF) xerrcnt <= xerrcnt + 8'd1;
      if (txen && state != EOF) begin
        hcnt <= half_end ? '0 : hcnt + HW'(1);
        if (half_end) ph <= !ph;
      end
      if (bit_end && in_crc) crc <= crc_nx;
      if (bit_end) begin
        bcnt <= bcnt + 3'd1;
        sh   <= sh >> 1;
      end
      case (state)
        IDLE: begin
          if (wr_ok) cnt <= cnt + CW'(1);
          if (xsnd && cnt + CW'(wr_ok) >= CW'(2)) state <= WAIT_CLR;
        end
        WAIT_CLR: if (!cardet) begin
          state <= PRE;
          sh    <= 8'h55;
          pcnt  <= 1'b0;
        end
        EOF: if (ecnt == EW'(EL - 1)) begin
          state <= IDLE;
          ecnt  <= '0;
          cnt   <= '0;
          crc   <= '0;
        end else ecnt <= ecnt + EW'(1);
        default: if (bit_end && bcnt == 3'd7) begin
          case (state)
            PRE: begin
              pcnt <= 1'b1;
              sh   <= pcnt ? 8'hD0 : 8'h55;
              if (pcnt) state <= SFD;
            end
            SFD: begin
              state <= DEST;
              sh    <= mem[0];
            end
            DEST: begin
              state <= SRC;
              sh    <= MAC_ADDR;
            end
            SRC: begin
              state <= TYPE;
              sh    <= mem[1];
              didx  <= CW'(2);
            end
            TYPE, DATA: if (didx < cnt) begin
              state <= DATA;
              sh    <= mem[didx[AW-1:0]];
              didx  <= didx + CW'(1);
            end else begin
              state <= has_crc ? CRC : EOF;
              sh    <= crc_nx;
            end
            default: state <= EOF;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wf_mx_xmit.sv
// tb_wf_mx_xmit: randomized frame checks of wf_mx_xmit against a byte-level frame model
module tb_wf_mx_xmit;
  logic       clk = 1'b0, rst = 1'b0, xwr = 1'b0, xsnd = 1'b0, cardet = 1'b0;
  logic [7:0] xdata = 8'h00;
  logic       txd, txen, xrdy;
  logic [7:0] xerrcnt;
  int         vecs = 0, errs = 0, last_wait = 0;

  wf_mx_xmit #(.CLK_FREQ(100), .BIT_RATE(10), .MAC_ADDR(8'h42), .EOF_BITS(2), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .xdata(xdata), .xwr(xwr), .xsnd(xsnd), .cardet(cardet),
    .txd(txd), .txen(txen), .xrdy(xrdy), .xerrcnt(xerrcnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] q[$]);
    logic [7:0] c = 8'h00;
    foreach (q[i])
      for (int k = 0; k < 8; k++) c = (c >> 1) ^ ((c[0] ^ q[i][k]) ? 8'hE0 : 8'h00);
    return c;
  endfunction

  task automatic wr(input logic [7:0] b);
    xdata = b; xwr = 1'b1;
    @(negedge clk);
    xwr = 1'b0;
  endtask

  task automatic snd();
    xsnd = 1'b1;
    @(negedge clk);
    xsnd = 1'b0;
  endtask

  task automatic load_send(input logic [7:0] p[$]);
    foreach (p[i]) wr(p[i]);
    snd();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // records txd once per clk while txen is high, then decodes bits from the mid-point of each first half
  task automatic capture(output logic [7:0] g[$], output int len, output int bad);
    logic s[$];
    int   w = 0, nb;
    g = {}; len = 0; bad = 0;
    while (!txen && w < 3000) begin @(negedge clk); w++; end
    last_wait = w;
    check("txen rise", 32'(txen), 1);
    while (txen && len < 6000) begin s.push_back(txd); len++; @(negedge clk); end
    check("txen fall", 32'(txen), 0);
    nb = len >= 20 ? (len - 20) / 80 : 0;
    for (int j = 0; j < nb * 8; j++) begin
      for (int k = 1; k < 5; k++)
        if (s[j*10+k] !== s[j*10] || s[j*10+5+k] !== s[j*10+5]) bad++;
      if (s[j*10+5] === s[j*10]) bad++;
    end
    for (int i = 0; i < nb; i++) begin
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = s[(i*8+k)*10+2];
      g.push_back(b);
    end
    for (int i = nb * 80; i < len; i++) if (s[i] !== 1'b1) bad++;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] p[$]);
    logic [7:0] e[$], g[$], body[$];
    int len, bad;
    e = {8'h55, 8'h55, 8'hD0, p[0], 8'h42, p[1]};
    for (int i = 2; i < p.size(); i++) e.push_back(p[i]);
    if (p[1] == 8'h31) begin
      body = e[3:$];
      e.push_back(crc8(body));
    end
    capture(g, len, bad);
    check({tag, " txen clks"}, len, e.size() * 80 + 20);
    check({tag, " nbytes"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(g[i]), 32'(e[i]));
    check({tag, " line errs"}, bad, 0);
    if (p[1] == 8'h31 && g.size() > 3) begin
      body = g[3:$];
      check({tag, " rx crc"}, 32'(crc8(body)), 0);
    end
  endtask

  initial begin
    logic [7:0] p[$];
    int n, hi;
    @(negedge clk);
    check("rst txd", 32'(txd), 1);
    check("rst txen", 32'(txen), 0);
    check("rst xrdy", 32'(xrdy), 1);
    check("rst xerrcnt", 32'(xerrcnt), 0);
    rst = 1'b1;
    @(negedge clk);

    p = {8'h2A, 8'h30, 8'h11, 8'h22};
    load_send(p);
    expect_frame("t1", p);
    check("t1 xrdy", 32'(xrdy), 1);

    p = {8'h2A, 8'h31, 8'hA5, 8'h5A, 8'h00, 8'hFF};
    load_send(p);
    expect_frame("t2", p);

    p = {8'h2A, 8'h30, 8'h5C};
    cardet = 1'b1;
    load_send(p);
    hi = 0;
    repeat (200) begin @(negedge clk); if (txen || !txd) hi++; end
    check("t3 held", hi, 0);
    cardet = 1'b0;
    fork
      expect_frame("t3", p);
      begin repeat (300) @(negedge clk); cardet = 1'b1; repeat (100) @(negedge clk); cardet = 1'b0; end
    join
    check("t3 start", last_wait, 1);

    p = {8'h2A, 8'h30};
    load_send(p);
    expect_frame("t4 hdr", p);
    wr(8'h2A);
    snd();
    hi = 0;
    repeat (100) begin @(negedge clk); if (txen) hi++; end
    check("t4 ignore", hi, 0);
    check("t4 xrdy", 32'(xrdy), 1);
    xdata = 8'h30; xwr = 1'b1; xsnd = 1'b1;
    @(negedge clk);
    xwr = 1'b0; xsnd = 1'b0;
    expect_frame("t4 wrsnd", p);

    repeat (12) begin
      n = $urandom_range(0, 8);
      p = {};
      p.push_back(8'($urandom));
      p.push_back($urandom_range(0, 1) ? 8'h31 : 8'($urandom));
      repeat (n) p.push_back(8'($urandom));
      cardet = 1'($urandom_range(0, 1));
      load_send(p);
      fork
        expect_frame("rnd", p);
        begin repeat ($urandom_range(1, 40)) @(negedge clk); cardet = 1'b0; end
      join
    end

    do_reset();
    check("t5 err0", 32'(xerrcnt), 0);
    p = {8'h2A, 8'h30};
    repeat (30) p.push_back(8'($urandom));
    foreach (p[i]) wr(p[i]);
    check("t5 full xrdy", 32'(xrdy), 0);
    repeat (3) wr(8'h99);
    check("t5 drops", 32'(xerrcnt), 3);
    check("t5 still full", 32'(xrdy), 0);
    snd();
    fork
      expect_frame("t5 full", p);
      begin repeat (300) @(negedge clk); repeat (10) wr(8'hEE); end
    join
    check("t5 busy drops", 32'(xerrcnt), 13);
    repeat (32) wr(8'h11);
    repeat (260) wr(8'h22);
    check("t5 saturate", 32'(xerrcnt), 8'hFF);

    do_reset();
    check("t6 err clr", 32'(xerrcnt), 0);
    p = {8'h2A, 8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_send(p);
    repeat (520) @(negedge clk);
    check("t6 midtx", 32'(txen), 1);
    rst = 1'b0;
    #1;
    check("t6 rst txen", 32'(txen), 0);
    check("t6 rst txd", 32'(txd), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6 xrdy", 32'(xrdy), 1);
    p = {8'h2A, 8'h31};
    load_send(p);
    expect_frame("t6 fresh", p);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
